audio_sample_sequencer: RTL and testbench
=========================================

# audio_sample_sequencer

Single-clock controller that sequences the guitar-filter datapath: it detects new audio ADC conversions, maintains the x[n]/x[n-1]/y[n-1] history, starts the IIR difference-equation block with a start/done handshake, and buffers results in a small FIFO. The FIFO is drained into the PWM DAC duty register on each PWM-ready request. Pot/filter-type changes are frozen and applied only between samples, so coefficients never change mid-computation. It replaces the scattered valid-edge always blocks that sat between the ADC, IIR, and PWM stages.

## Interface
- N, 10, audio sample / duty width
- FW, 10, pot (frequency) word width
- DEPTH, 4, output FIFO depth; power of 2, ≥2
- TIMEOUT, 255, max cycles in WAIT before filter fault
- clk  in  1  system clock (50 MHz PLL domain)
- reset_n  in  1  asynchronous, active-low reset
- audio_valid  in  1  ADC conversion-ready level; asynchronous, synchronized internally
- audio_adc  in  N  ADC word; stable while audio_valid high
- pot_valid  in  1  pot conversion-ready level; asynchronous, synchronized internally
- pot_word  in  FW  selected pot ADC word
- filt_type  in  1  0 LPF, 1 HPF; asynchronous switch
- filt_start  out  1  one-cycle start pulse to IIR
- filt_x0, filt_x1, filt_y1  out  N each  x[n], x[n-1], y[n-1] to IIR
- filt_f_word  out  FW  frozen pot word to frequency converter
- filt_type_q  out  1  frozen filter type
- filt_done  in  1  IIR result valid; sampled only in WAIT
- filt_y  in  N  IIR result
- pwm_ready  in  1  PWM next-duty request; asynchronous, synchronized internally
- duty_val  out  N  PWM duty register
- busy  out  1  high in any state except IDLE
- fault  out  1  sticky; set on filter timeout

## Operation
- audio_valid, pot_valid, pwm_ready, filt_type: 2-FF synchronizers, plus a third register for rising-edge detection.
- Pot rising edge, any state: pend_f <= pot_word; pend_t <= synced filt_type.
- FSM IDLE -> LATCH -> START -> WAIT -> STORE -> IDLE.
- IDLE: on audio rising edge -> LATCH.
- LATCH: x1 <= x0; x0 <= audio_adc; filt_f_word <= pend_f; filt_type_q <= pend_t.
- START: filt_start = 1 for exactly one cycle; clear the timeout counter.
- WAIT: if filt_done, capture filt_y -> STORE. Otherwise, when the counter reaches TIMEOUT, set fault, use y1 (hold) as the result -> STORE.
- STORE: y1 <= result; push result into the FIFO -> IDLE.
- Audio edge outside IDLE: sample dropped (overrun).
- Push when FIFO full: new result dropped (overrun); y1 is still updated.
- PWM rising edge, FIFO non-empty: pop; duty_val <= head.
- PWM rising edge, FIFO empty: duty_val holds (underrun).
- Push and pop in the same cycle: both occur. Full stays full with no drop; empty pops nothing (underrun) and the push lands.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full and empty are decoded from the MSB plus equal low bits.
- All arithmetic is pass-through; no widths change. filt_y is taken as N bits unsigned.

## Timing
- Reset values:
  - duty_val, x0, x1, y1: 2^(N-1) (midscale)
  - filt_f_word, pend_f, filt_type_q, pend_t: 0
  - filt_start, busy, fault: 0
  - FIFO: empty; FSM: IDLE
- Reset mid-operation aborts immediately. No filt_start is issued until a new audio edge after release.
- audio_valid is first sampled high on edge k: LATCH at k+3, filt_start high in cycle k+4.
- filt_done seen on edge d: STORE at d+1; FIFO count increments at d+2.
- Minimum sample period: 6 cycles plus filter latency.
- pwm_ready is first sampled high on edge p: duty_val updates on edge p+3.
- A pot edge on the same cycle as LATCH applies to the next sample, not the current one.

## Configuration
- SEQ_STATS_EN defined: adds outputs overrun_cnt and underrun_cnt, 8 bits each.
  - Both saturate at 255 and reset to 0.
  - A dropped audio edge and a full-FIFO drop each add 1 to overrun_cnt.
- SEQ_STATS_EN undefined: those ports and counters do not exist; behaviour is otherwise identical.

## Structure
- Package audio_seq_pkg holds:
  - the state enum seq_state_t (IDLE, LATCH, START, WAIT, STORE)
  - the midscale constant function
  - the default N, FW, DEPTH values
- Sub-module seq_sync_edge: 2-FF synchronizer plus rising-edge detector. Instantiated for audio_valid, pot_valid, and pwm_ready; its synchronizer is reused for filt_type.
- FIFO inline in the top module.

## Test plan
- Reset, then 3 audio edges, each with filt_done 5 cycles after filt_start and filt_y = 100, 200, 300:
  - filt_x0/x1 sequence: 512/512 -> a/512 -> b/a.
  - filt_y1 = 300 at the end.
  - FIFO count = 3.
- Four pwm_ready edges after the above: duty_val = 100, 200, 300, then holds 300 (underrun).
- filt_done never asserted: fault sets exactly TIMEOUT+1 cycles after START; the FIFO receives the prior y1 (512); the FSM returns to IDLE.
- Five results pushed with DEPTH=4 and no pops: the fifth is dropped; pops return the first four. With SEQ_STATS_EN, overrun_cnt = 1.
- Pot word changed 700 -> 300 during WAIT: filt_f_word stays 700 until the next LATCH, then becomes 300.
- reset_n pulsed low during WAIT: all outputs return to reset values asynchronously, and no filt_start occurs without a new audio edge.

Source files
------------

// File: rtl/audio_sample_sequencer_pkg.sv
// Shared types and defaults for the audio sample sequencer: FSM state encoding,
// default widths/depth and the midscale helper used for reset values.
package audio_seq_pkg;

    localparam int N_DEF       = 10;
    localparam int FW_DEF      = 10;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        START,
        WAIT,
        STORE
    } seq_state_t;

    function automatic logic [31:0] midscale(input int n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/audio_sample_sequencer_if.sv
// Start/done handshake and operand bus between the sequencer (master) and the
// IIR difference-equation block (slave).
interface audio_sample_sequencer_if
    import audio_seq_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int FW = FW_DEF
);
    logic          filt_start;
    logic [N-1:0]  filt_x0;
    logic [N-1:0]  filt_x1;
    logic [N-1:0]  filt_y1;
    logic [FW-1:0] filt_f_word;
    logic          filt_type_q;
    logic          filt_done;
    logic [N-1:0]  filt_y;

    modport master (
        output filt_start, filt_x0, filt_x1, filt_y1, filt_f_word, filt_type_q,
        input  filt_done, filt_y
    );

    modport slave (
        input  filt_start, filt_x0, filt_x1, filt_y1, filt_f_word, filt_type_q,
        output filt_done, filt_y
    );
endinterface

// File: rtl/audio_sample_sequencer_sync.sv
// seq_sync_edge: two-flop synchronizer for an asynchronous level, plus a
// registered one-cycle rising-edge pulse.
module seq_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
endmodule

// File: rtl/audio_sample_sequencer.sv
// Sequences ADC samples through the IIR block and buffers results for the PWM DAC.
// Optional build macro SEQ_STATS_EN adds saturating overrun/underrun counters.
module audio_sample_sequencer
    import audio_seq_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int FW      = FW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_valid,
    input  logic [N-1:0]             audio_adc,
    input  logic                     pot_valid,
    input  logic [FW-1:0]            pot_word,
    input  logic                     filt_type,
    audio_sample_sequencer_if.master filt,
    input  logic                     pwm_ready,
    output logic [N-1:0]             duty_val,
    output logic                     busy,
    output logic                     fault
`ifdef SEQ_STATS_EN
    ,
    output logic [7:0]               overrun_cnt,
    output logic [7:0]               underrun_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [N-1:0] MID = N'(midscale(N));

    // Index 0: audio_valid, 1: pot_valid, 2: pwm_ready.
    logic [2:0] async_in;
    logic [2:0] rise_v;
    logic [2:0] sync_unused;
    logic       type_sync;
    logic       type_rise_unused;

    assign async_in = {pwm_ready, pot_valid, audio_valid};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            seq_sync_edge u_sync (
                .clk    (clk),
                .reset_n(reset_n),
                .d_i    (async_in[gi]),
                .sync_o (sync_unused[gi]),
                .rise_o (rise_v[gi])
            );
        end
    endgenerate

    seq_sync_edge u_type_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d_i    (filt_type),
        .sync_o (type_sync),
        .rise_o (type_rise_unused)
    );

    logic audio_rise, pot_rise, pwm_rise;
    assign audio_rise = rise_v[0];
    assign pot_rise   = rise_v[1];
    assign pwm_rise   = rise_v[2];

    // Pot settings are staged here and only copied to the filter in LATCH.
    logic [FW-1:0] pend_f_q;
    logic          pend_t_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_f_q <= '0;
            pend_t_q <= 1'b0;
        end else if (pot_rise) begin
            pend_f_q <= pot_word;
            pend_t_q <= type_sync;
        end
    end

    seq_state_t    state_q;
    logic          start_q;
    logic [N-1:0]  x0_q, x1_q, y1_q, result_q;
    logic [FW-1:0] f_word_q;
    logic          type_q;
    logic [TW-1:0] tmo_q;
    logic          fault_q;
    logic          push_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            x0_q     <= MID;
            x1_q     <= MID;
            y1_q     <= MID;
            result_q <= MID;
            f_word_q <= '0;
            type_q   <= 1'b0;
            tmo_q    <= '0;
            fault_q  <= 1'b0;
            push_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            push_q  <= 1'b0;
            case (state_q)
                IDLE: if (audio_rise) state_q <= LATCH;
                LATCH: begin
                    x1_q     <= x0_q;
                    x0_q     <= audio_adc;
                    f_word_q <= pend_f_q;
                    type_q   <= pend_t_q;
                    start_q  <= 1'b1;
                    state_q  <= START;
                end
                START: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (filt.filt_done) begin
                        result_q <= filt.filt_y;
                        state_q  <= STORE;
                    end else if (tmo_q == TW'(TIMEOUT)) begin
                        // Filter never answered: hold the previous output.
                        fault_q  <= 1'b1;
                        result_q <= y1_q;
                        state_q  <= STORE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                STORE: begin
                    y1_q    <= result_q;
                    push_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign filt.filt_start  = start_q;
    assign filt.filt_x0     = x0_q;
    assign filt.filt_x1     = x1_q;
    assign filt.filt_y1     = y1_q;
    assign filt.filt_f_word = f_word_q;
    assign filt.filt_type_q = type_q;
    assign busy             = (state_q != IDLE);
    assign fault            = fault_q;

    // Output FIFO; the push payload is y1, which STORE has just refreshed.
    logic [N-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic         fifo_empty, fifo_full, pop_ok, push_ok;
    logic [N-1:0] duty_q;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok     = pwm_rise && !fifo_empty;
        push_ok    = push_q && (!fifo_full || pop_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= y1_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            duty_q   <= MID;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (pop_ok) duty_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign duty_val = duty_q;

`ifdef SEQ_STATS_EN
    logic [7:0] overrun_q, underrun_q, overrun_d, underrun_d;
    logic [8:0] over_sum, under_sum;
    logic       audio_drop, push_drop, pwm_under;

    always_comb begin
        audio_drop = audio_rise && (state_q != IDLE);
        push_drop  = push_q && !push_ok;
        pwm_under  = pwm_rise && fifo_empty;
        over_sum   = {1'b0, overrun_q} + 9'(audio_drop) + 9'(push_drop);
        under_sum  = {1'b0, underrun_q} + 9'(pwm_under);
        overrun_d  = over_sum[8] ? 8'hFF : over_sum[7:0];
        underrun_d = under_sum[8] ? 8'hFF : under_sum[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q  <= '0;
            underrun_q <= '0;
        end else begin
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign overrun_cnt  = overrun_q;
    assign underrun_cnt = underrun_q;
`endif
endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed bench for audio_sample_sequencer: sample table, PWM drain table and
// hand-written timeout, overflow, pot-freeze and mid-operation reset sequences.
module tb_audio_sample_sequencer;
    import audio_seq_pkg::*;

    localparam int N       = 10;
    localparam int FW      = 10;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          audio_valid = 1'b0;
    logic [N-1:0]  audio_adc = '0;
    logic          pot_valid = 1'b0;
    logic [FW-1:0] pot_word = '0;
    logic          filt_type = 1'b0;
    logic          pwm_ready = 1'b0;
    logic [N-1:0]  duty_val;
    logic          busy;
    logic          fault;
`ifdef SEQ_STATS_EN
    logic [7:0]    overrun_cnt;
    logic [7:0]    underrun_cnt;
`endif

    audio_sample_sequencer_if #(.N(N), .FW(FW)) filt_if ();

    audio_sample_sequencer #(
        .N(N), .FW(FW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .audio_valid (audio_valid),
        .audio_adc   (audio_adc),
        .pot_valid   (pot_valid),
        .pot_word    (pot_word),
        .filt_type   (filt_type),
        .filt        (filt_if),
        .pwm_ready   (pwm_ready),
        .duty_val    (duty_val),
        .busy        (busy),
        .fault       (fault)
`ifdef SEQ_STATS_EN
        ,
        .overrun_cnt (overrun_cnt),
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int adc;
        int fy;
        int exp_x0;
        int exp_x1;
        int exp_y1_in;
        int exp_y1_out;
    } samp_vec_t;

    samp_vec_t svec [3];
    int        duty_exp [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got no response expected response within bound", name);
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        audio_valid = 1'b0;
        pot_valid   = 1'b0;
        pwm_ready   = 1'b0;
        filt_if.filt_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Raises audio_valid and returns at the falling edge where filt_start is seen.
    task automatic start_sample(input int adc, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1 audio_adc = N'(adc);
        audio_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (filt_if.filt_start) begin
                ok = 1'b1;
                break;
            end
        end
        audio_valid = 1'b0;
        if (!ok) bound_fail("filt_start_wait");
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) bound_fail(name);
    endtask

    task automatic finish_sample(input int dly, input int fy);
        repeat (dly) @(posedge clk);
        #1 filt_if.filt_done = 1'b1;
        filt_if.filt_y = N'(fy);
        @(posedge clk);
        #1 filt_if.filt_done = 1'b0;
        wait_idle("idle_after_done");
        repeat (2) @(posedge clk);
        #1 $display("sample done y=%0d y1=%0d x0=%0d x1=%0d",
                    fy, filt_if.filt_y1, filt_if.filt_x0, filt_if.filt_x1);
    endtask

    task automatic pwm_pulse();
        @(posedge clk);
        #1 pwm_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 pwm_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 $display("pwm request duty=%0d", duty_val);
    endtask

    task automatic pot_pulse(input int word, input bit typ);
        @(posedge clk);
        #1 pot_word = FW'(word);
        filt_type = typ;
        pot_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 pot_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 $display("pot update word=%0d type=%0d", word, typ);
    endtask

    initial begin
        bit ok;
        int n;
        int starts;

        svec[0] = '{adc: 11, fy: 100, exp_x0: 11, exp_x1: 512, exp_y1_in: 512, exp_y1_out: 100};
        svec[1] = '{adc: 22, fy: 200, exp_x0: 22, exp_x1: 11,  exp_y1_in: 100, exp_y1_out: 200};
        svec[2] = '{adc: 33, fy: 300, exp_x0: 33, exp_x1: 22,  exp_y1_in: 200, exp_y1_out: 300};
        duty_exp = '{100, 200, 300, 300};
        filt_if.filt_done = 1'b0;
        filt_if.filt_y    = '0;

        // Reset values
        do_reset();
        chk("rst_duty",   int'(duty_val), 512);
        chk("rst_x0",     int'(filt_if.filt_x0), 512);
        chk("rst_x1",     int'(filt_if.filt_x1), 512);
        chk("rst_y1",     int'(filt_if.filt_y1), 512);
        chk("rst_fword",  int'(filt_if.filt_f_word), 0);
        chk("rst_typeq",  int'(filt_if.filt_type_q), 0);
        chk("rst_start",  int'(filt_if.filt_start), 0);
        chk("rst_busy",   int'(busy), 0);
        chk("rst_fault",  int'(fault), 0);

        // Table of three samples, filt_done five cycles after filt_start
        for (int i = 0; i < 3; i++) begin
            start_sample(svec[i].adc, ok);
            chk($sformatf("s%0d_x0", i), int'(filt_if.filt_x0), svec[i].exp_x0);
            chk($sformatf("s%0d_x1", i), int'(filt_if.filt_x1), svec[i].exp_x1);
            chk($sformatf("s%0d_y1_in", i), int'(filt_if.filt_y1), svec[i].exp_y1_in);
            chk($sformatf("s%0d_busy", i), int'(busy), 1);
            finish_sample(5, svec[i].fy);
            chk($sformatf("s%0d_y1_out", i), int'(filt_if.filt_y1), svec[i].exp_y1_out);
        end
        chk("fifo_no_early_pop", int'(duty_val), 512);

        // Drain: three results then underrun hold
        for (int i = 0; i < 4; i++) begin
            pwm_pulse();
            chk($sformatf("drain%0d_duty", i), int'(duty_val), duty_exp[i]);
        end
`ifdef SEQ_STATS_EN
        chk("underrun_cnt", int'(underrun_cnt), 1);
`endif

        // Filter timeout: fault TIMEOUT+1 cycles after START, prior y1 pushed
        do_reset();
        start_sample(44, ok);
        @(posedge clk);
        n = 401;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (fault) begin
                n = i;
                break;
            end
        end
        chk("timeout_latency", n, TIMEOUT + 1);
        wait_idle("idle_after_timeout");
        chk("timeout_idle", int'(busy), 0);
        chk("timeout_y1_hold", int'(filt_if.filt_y1), 512);
        start_sample(55, ok);
        finish_sample(3, 100);
        chk("fault_sticky", int'(fault), 1);
        pwm_pulse();
        chk("timeout_pop0", int'(duty_val), 512);
        pwm_pulse();
        chk("timeout_pop1", int'(duty_val), 100);

        // Five pushes into a four-deep FIFO: the fifth is dropped
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            start_sample(i, ok);
            finish_sample(1, i * 10);
        end
        chk("ovf_y1", int'(filt_if.filt_y1), 50);
`ifdef SEQ_STATS_EN
        chk("overrun_cnt", int'(overrun_cnt), 1);
`endif
        for (int i = 1; i <= 5; i++) begin
            pwm_pulse();
            chk($sformatf("ovf_pop%0d", i), int'(duty_val), (i < 5) ? i * 10 : 40);
        end

        // Pot change during WAIT only takes effect at the next LATCH
        do_reset();
        pot_pulse(700, 1'b0);
        start_sample(66, ok);
        chk("pot_fword_first", int'(filt_if.filt_f_word), 700);
        pot_pulse(300, 1'b1);
        chk("pot_busy_in_wait", int'(busy), 1);
        chk("pot_frozen_word", int'(filt_if.filt_f_word), 700);
        chk("pot_frozen_type", int'(filt_if.filt_type_q), 0);
        finish_sample(1, 5);
        chk("pot_still_frozen", int'(filt_if.filt_f_word), 700);
        start_sample(77, ok);
        chk("pot_applied_word", int'(filt_if.filt_f_word), 300);
        chk("pot_applied_type", int'(filt_if.filt_type_q), 1);
        finish_sample(1, 6);

        // Asynchronous reset during WAIT
        start_sample(88, ok);
        repeat (3) @(posedge clk);
        #5 reset_n = 1'b0;
        #1;
        chk("arst_busy",  int'(busy), 0);
        chk("arst_x0",    int'(filt_if.filt_x0), 512);
        chk("arst_x1",    int'(filt_if.filt_x1), 512);
        chk("arst_y1",    int'(filt_if.filt_y1), 512);
        chk("arst_duty",  int'(duty_val), 512);
        chk("arst_fword", int'(filt_if.filt_f_word), 0);
        chk("arst_typeq", int'(filt_if.filt_type_q), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (filt_if.filt_start) starts++;
        end
        chk("arst_no_start", starts, 0);
        chk("arst_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
